mmio_responder: RTL

Memory-mapped peripheral that answers the CPU's memory bus (Address / Wr / Datain / Dataout) in a 16-byte window beside the 256-byte Memory. It provides a 4-entry byte transmit FIFO drained over a valid/ready port, a status register, and a free-running timer with compare interrupt. The top level selects Dataout from this block instead of Memory whenever Hit is asserted.

---
 rtl/mmio_responder.sv | 113 +++++++++++
 1 files changed

// File: rtl/mmio_responder.sv
// Memory-mapped TX FIFO, status flags and compare timer answering the CPU bus
// in a 16-byte window at BASE; Dataout is registered to match Memory's latency.
module mmio_responder #(
    parameter logic [31:0] BASE  = 32'h00000100,
    parameter int          DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Address,
    input  logic        Wr,
    input  logic [31:0] Datain,
    output logic [31:0] Dataout,
    output logic        Hit,
    output logic [7:0]  TxData,
    output logic        TxValid,
    input  logic        TxReady,
    output logic        Irq
);
    localparam int             PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0]     FULL_CNT = 3'(DEPTH);
    localparam logic [PW-1:0]  LAST     = PW'(DEPTH - 1);

    localparam logic [1:0] OFF_DATA = 2'd0, OFF_STATUS = 2'd1,
                           OFF_TIMER = 2'd2, OFF_COMPARE = 2'd3;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]    count_q, count_d;
    logic          ovf_q, ovf_d, irq_q, irq_d;
    logic [31:0]   timer_q, timer_d, cmp_q, cmp_d, dout_q, dout_d;

    logic [1:0]    off;
    logic          empty, full, wr_hit, push_req, push_ok, pop;
    logic [31:0]   status, rd_val;

    assign Hit     = (Address[31:4] == BASE[31:4]);
    assign off     = Address[3:2];
    assign empty   = (count_q == 3'd0);
    assign full    = (count_q == FULL_CNT);
    assign TxValid = !empty;
    assign TxData  = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign Irq     = irq_q;
    assign Dataout = dout_q;

    assign wr_hit   = Wr && Hit;
    assign push_req = wr_hit && (off == OFF_DATA);
    assign pop      = TxValid && TxReady;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign push_ok  = push_req && (!full || pop);
    assign status   = {25'd0, count_q, irq_q, ovf_q, full, empty};

    always_comb begin
        rd_val = 32'd0;
        case (off)
            OFF_DATA:    rd_val = {24'd0, TxData};
            OFF_STATUS:  rd_val = status;
            OFF_TIMER:   rd_val = timer_q;
            OFF_COMPARE: rd_val = cmp_q;
            default:     rd_val = 32'd0;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase

        // Clear first, then set, so a coincident set wins.
        ovf_d = ovf_q;
        irq_d = irq_q;
        if (wr_hit && off == OFF_STATUS && Datain[2]) ovf_d = 1'b0;
        if (wr_hit && off == OFF_STATUS && Datain[3]) irq_d = 1'b0;
        if (push_req && full && !pop)                 ovf_d = 1'b1;
        if (timer_q == cmp_q)                         irq_d = 1'b1;

        timer_d = (wr_hit && off == OFF_TIMER) ? Datain : timer_q + 32'd1;
        cmp_d   = (wr_hit && off == OFF_COMPARE) ? Datain : cmp_q;
        dout_d  = (Hit && !Wr) ? rd_val : 32'd0;
    end

    always_ff @(posedge Clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= Datain[7:0];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 3'd0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
            timer_q  <= 32'd0;
            cmp_q    <= 32'hFFFFFFFF;
            dout_q   <= 32'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
            timer_q  <= timer_d;
            cmp_q    <= cmp_d;
            dout_q   <= dout_d;
        end
    end
endmodule
